// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, column drive patterns and key map.
// Imported by the scanner and the guess-entry controller.
package keypad_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hE;
   localparam logic [3:0] KEY_BKSP  = 4'hF;
   localparam logic [3:0] KEY_CLR   = 4'hC;

   // Out of the 4-bit code range so it never aliases a real key
   localparam logic [4:0] KEY_NONE  = 5'h10;

   localparam logic [3:0] COL1_DRV = 4'b0111;
   localparam logic [3:0] COL2_DRV = 4'b1011;
   localparam logic [3:0] COL3_DRV = 4'b1101;
   localparam logic [3:0] COL4_DRV = 4'b1110;

   typedef enum logic [1:0] {
      COL1,
      COL2,
      COL3,
      COL4
   } col_t;

   typedef enum logic {
      EDIT,
      SUBMIT
   } entry_t;

   function automatic logic [3:0] col_drive(input col_t c);
      logic [3:0] d;
      d = 4'b1111;
      unique case (c)
         COL1: d = COL1_DRV;
         COL2: d = COL2_DRV;
         COL3: d = COL3_DRV;
         COL4: d = COL4_DRV;
         default: d = 4'b1111;
      endcase
      return d;
   endfunction

   // r is the row index, 0 = R1 .. 3 = R4
   function automatic logic [3:0] key_of(input col_t c,
                                         input logic [1:0] r);
      logic [3:0] k;
      k = 4'h0;
      unique case ({c, r})
         4'h0: k = 4'h1;
         4'h1: k = 4'h4;
         4'h2: k = 4'h7;
         4'h3: k = 4'h0;
         4'h4: k = 4'h2;
         4'h5: k = 4'h5;
         4'h6: k = 4'h8;
         4'h7: k = 4'hF;
         4'h8: k = 4'h3;
         4'h9: k = 4'h6;
         4'hA: k = 4'h9;
         4'hB: k = 4'hE;
         4'hC: k = 4'hA;
         4'hD: k = 4'hB;
         4'hE: k = 4'hC;
         4'hF: k = 4'hD;
         default: k = 4'h0;
      endcase
      return k;
   endfunction

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'h9;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with per-frame ghost rejection and debounce.
// Emits a single-cycle key_valid per accepted press; held keys never repeat.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS     = 100000,
   parameter int SETTLE         = 8,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

   col_t          col_q, col_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          tick_end;
   logic          sample;

   logic [3:0]    hits;
   logic [2:0]    nbits;
   logic [1:0]    row_idx;
   logic [3:0]    col_code;
   logic [2:0]    sum;

   logic [1:0]    acc_q;
   logic [3:0]    acc_code_q;
   logic [3:0]    frame_code;
   logic [4:0]    frame_res;
   logic          frame_done;

   logic [4:0]    cand_q, cand_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          rep_q, rep_d;
   logic          stable;
   logic          fire;

   assign tick_end = tick_q == TW'(SCAN_TICKS - 1);
   assign sample   = tick_q == TW'(SETTLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q  <= COL1;
         tick_q <= '0;
      end else begin
         col_q  <= col_d;
         tick_q <= tick_d;
      end
   end

   always_comb begin
      col_d  = col_q;
      tick_d = tick_end ? '0 : tick_q + TW'(1);
      if (tick_end) begin
         unique case (col_q)
            COL1: col_d = COL2;
            COL2: col_d = COL3;
            COL3: col_d = COL4;
            COL4: col_d = COL1;
            default: col_d = COL1;
         endcase
      end
   end

   assign Col = rst ? 4'b1111 : col_drive(col_q);

   assign hits  = ~Row;
   assign nbits = 3'(hits[0]) + 3'(hits[1])
                + 3'(hits[2]) + 3'(hits[3]);

   always_comb begin
      row_idx = '0;
      for (int r = 0; r < 4; r++) begin
         if (hits[3-r]) row_idx = 2'(r);
      end
   end

   assign col_code   = key_of(col_q, row_idx);
   assign sum        = 3'(acc_q) + nbits;
   assign frame_code = (nbits == 3'd1) ? col_code : acc_code_q;
   assign frame_done = sample && (col_q == COL4);
   assign frame_res  = (sum == 3'd1) ? {1'b0, frame_code} : KEY_NONE;

   // Bit count saturates at 2: anything above one hit is a ghost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         acc_code_q <= '0;
      end else if (sample) begin
         if (col_q == COL4) begin
            acc_q      <= '0;
            acc_code_q <= '0;
         end else begin
            acc_q      <= (sum >= 3'd2) ? 2'd2 : sum[1:0];
            acc_code_q <= frame_code;
         end
      end
   end

   always_comb begin
      cand_d = frame_res;
      if (frame_res == cand_q) begin
         cnt_d = (cnt_q == DW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + DW'(1);
      end else begin
         cnt_d = DW'(1);
      end
      stable = cnt_d == DW'(DEBOUNCE_SCANS);
      fire   = frame_done && stable && (cand_d != KEY_NONE) && !rep_q;
      rep_d  = stable ? (cand_d != KEY_NONE) : rep_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q    <= KEY_NONE;
         cnt_q     <= '0;
         rep_q     <= 1'b0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         key_valid <= fire;
         if (frame_done) begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            rep_q  <= rep_d;
         end
         if (fire) key_code <= cand_d[3:0];
      end
   end

endmodule

// File: rtl/guess_entry_ctrl.sv
// Numberle guess entry: keypad scanner plus digit buffer with editing
// keys and a valid/ack handoff of the completed guess.
module guess_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS     = 100000,
   parameter int SETTLE         = 8,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int GUESS_LEN      = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             Row,
   output logic [3:0]             Col,
   output logic                   key_valid,
   output logic [3:0]             key_code,
   output logic [4*GUESS_LEN-1:0] guess_digits,
   output logic [2:0]             guess_count,
   output logic                   guess_valid,
   input  logic                   guess_ack
);

   entry_t                      st_q, st_d;
   logic [GUESS_LEN-1:0][3:0]   dig_q, dig_d;
   logic [2:0]                  cnt_q, cnt_d;

   keypad_scanner #(
      .SCAN_TICKS     (SCAN_TICKS),
      .SETTLE         (SETTLE),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .Row       (Row),
      .Col       (Col),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= EDIT;
         dig_q <= '0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         dig_q <= dig_d;
         cnt_q <= cnt_d;
      end
   end

   // Slot s lives in nibble GUESS_LEN-1-s so the first digit is the MSB
   always_comb begin
      st_d  = st_q;
      dig_d = dig_q;
      cnt_d = cnt_q;
      unique case (st_q)
         EDIT: begin
            if (key_valid) begin
               unique case (1'b1)
                  is_digit(key_code): begin
                     if (cnt_q < 3'(GUESS_LEN)) begin
                        for (int s = 0; s < GUESS_LEN; s++) begin
                           if (3'(s) == cnt_q) dig_d[GUESS_LEN-1-s] = key_code;
                        end
                        cnt_d = cnt_q + 3'd1;
                     end
                  end
                  (key_code == KEY_BKSP): begin
                     if (cnt_q != 3'd0) begin
                        for (int s = 0; s < GUESS_LEN; s++) begin
                           if (3'(s) == cnt_q - 3'd1) dig_d[GUESS_LEN-1-s] = 4'h0;
                        end
                        cnt_d = cnt_q - 3'd1;
                     end
                  end
                  (key_code == KEY_CLR): begin
                     dig_d = '0;
                     cnt_d = '0;
                  end
                  (key_code == KEY_ENTER): begin
                     if (cnt_q == 3'(GUESS_LEN)) st_d = SUBMIT;
                  end
                  default: ;
               endcase
            end
         end
         SUBMIT: begin
            if (guess_ack) begin
               st_d  = EDIT;
               dig_d = '0;
               cnt_d = '0;
            end
         end
         default: st_d = EDIT;
      endcase
   end

   assign guess_digits = dig_q;
   assign guess_count  = cnt_q;
   assign guess_valid  = st_q == SUBMIT;

endmodule
